// File: rtl/keys_input_pio_if.sv
`default_nettype none
// ============================================================================
// Module      : keys_input_pio_if
// Description : Avalon-MM slave bus plus interrupt line for the key PIO.
// Revision    : 1.0 - initial release
// ============================================================================
interface keys_input_pio_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );
endinterface
`default_nettype wire

// File: rtl/keys_input_pio.sv
`default_nettype none
// ============================================================================
// Module      : keys_input_pio
// Description : Pushbutton input PIO with falling-edge capture and level IRQ.
//               Define KEYS_INPUT_PIO_DEBOUNCE_EN to add per-bit debouncing.
// Revision    : 1.0 - initial release
// ============================================================================
module keys_input_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  wire logic             clk,
   input  wire logic             reset_n,
   keys_input_pio_if.slave       bus,
   input  wire logic [WIDTH-1:0] in_port
);
   localparam logic [1:0] c_addr_data = 2'd0;
   localparam logic [1:0] c_addr_mask = 2'd2;
   localparam logic [1:0] c_addr_edge = 2'd3;

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_mask;
   logic [WIDTH-1:0] r_edgecap;
   logic             r_irq;
   logic [WIDTH-1:0] w_level;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_clr;
   logic             w_wr;
   logic             w_unused;

   if (DEBOUNCE_CYCLES < 1) begin : g_illegal_cfg
      $error("keys_input_pio: DEBOUNCE_CYCLES must be at least 1");
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '1;
         r_sync2 <= '1;
      end else begin
         r_sync1 <= in_port;
         r_sync2 <= r_sync1;
      end
   end

`ifdef KEYS_INPUT_PIO_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

   for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
      logic [CNT_W-1:0] r_cnt;
      logic             r_deb;

      // Counter tracks consecutive disagreeing cycles; any agreement restarts it.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_cnt <= '0;
            r_deb <= 1'b1;
         end else if (r_sync2[i] == r_deb) begin
            r_cnt <= '0;
         end else if (r_cnt == c_cnt_last) begin
            r_cnt <= '0;
            r_deb <= r_sync2[i];
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      assign w_level[i] = r_deb;
   end
`else
   assign w_level = r_sync2;
`endif

   assign w_wr   = bus.chipselect && !bus.write_n;
   assign w_fall = r_prev & ~w_level;
   assign w_clr  = (w_wr && bus.address == c_addr_edge) ? bus.writedata[WIDTH-1:0] : '0;

   // A capture arriving in the same cycle as its clear must survive.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev    <= '1;
         r_mask    <= '0;
         r_edgecap <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_prev    <= w_level;
         r_edgecap <= (r_edgecap & ~w_clr) | w_fall;
         r_irq     <= |(r_edgecap & r_mask);
         if (w_wr && bus.address == c_addr_mask) begin
            r_mask <= bus.writedata[WIDTH-1:0];
         end
      end
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         c_addr_data: bus.readdata = 32'(w_level);
         c_addr_mask: bus.readdata = 32'(r_mask);
         c_addr_edge: bus.readdata = 32'(r_edgecap);
         default:     bus.readdata = '0;
      endcase
   end

   assign bus.irq  = r_irq;
   assign w_unused = ^bus.writedata;
endmodule
`default_nettype wire

// File: tb/tb_keys_input_pio.sv
`default_nettype none
// ============================================================================
// Module      : tb_keys_input_pio
// Description : Directed self-checking bench for keys_input_pio.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keys_input_pio;
   localparam int WIDTH = 4;
   localparam int DEB   = 8;
`ifdef KEYS_INPUT_PIO_DEBOUNCE_EN
   localparam int LAT = 2 + DEB;
`else
   localparam int LAT = 2;
`endif

   logic             clk;
   logic             reset_n;
   logic [WIDTH-1:0] in_port;
   int               checks;
   int               failures;

   keys_input_pio_if bus ();

   keys_input_pio #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .in_port (in_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
      bus.address    = a;
      bus.chipselect = 1'b1;
      #1;
      chk(tag, bus.readdata, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(posedge clk);
      #1;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
   endtask

   initial begin
      checks         = 0;
      failures       = 0;
      reset_n        = 1'b0;
      in_port        = 4'hF;
      bus.address    = 2'd0;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = '0;
      tick(3);
      chk("irq_in_reset", {31'd0, bus.irq}, 32'd0);
      rd(2'd2, 32'h0, "mask_in_reset");
      reset_n = 1'b1;
      tick(LAT + 2);

      rd(2'd0, 32'h0000000F, "reset_data");
      rd(2'd2, 32'h0, "reset_mask");
      rd(2'd3, 32'h0, "reset_edge");
      chk("reset_irq", {31'd0, bus.irq}, 32'd0);

      wr(2'd2, 32'h2);
      rd(2'd2, 32'h2, "mask_write");
      wr(2'd0, 32'h0);
      rd(2'd0, 32'hF, "data_ignores_write");
      wr(2'd1, 32'hFFFF_FFFF);
      rd(2'd1, 32'h0, "reserved_reads_zero");

      // Falling edge on bit 1 with bit 1 unmasked
      in_port = 4'b1101;
      tick(LAT);
      rd(2'd0, 32'hD, "data_after_fall");
      rd(2'd3, 32'h0, "edge_not_yet");
      tick(1);
      rd(2'd3, 32'h2, "edge_bit1_set");
      chk("irq_not_yet", {31'd0, bus.irq}, 32'd0);
      tick(1);
      chk("irq_bit1", {31'd0, bus.irq}, 32'd1);
      wr(2'd3, 32'h2);
      rd(2'd3, 32'h0, "edge_cleared");
      chk("irq_lags_clear", {31'd0, bus.irq}, 32'd1);
      tick(1);
      chk("irq_after_clear", {31'd0, bus.irq}, 32'd0);

      in_port = 4'hF;
      tick(LAT + 2);
      rd(2'd3, 32'h0, "rise_no_edge");
      rd(2'd0, 32'hF, "data_after_rise");

`ifdef KEYS_INPUT_PIO_DEBOUNCE_EN
      in_port = 4'hE;
      tick(5);
      in_port = 4'hF;
      tick(12);
      rd(2'd0, 32'hF, "glitch_data");
      rd(2'd3, 32'h0, "glitch_edge");
      in_port = 4'hE;
      tick(12);
      rd(2'd0, 32'hE, "held_data");
      rd(2'd3, 32'h1, "held_edge");
      in_port = 4'hF;
      tick(LAT + 2);
      wr(2'd3, 32'h1);
      rd(2'd3, 32'h0, "held_edge_cleared");
`endif

      // Masked pending capture, then unmask
      wr(2'd2, 32'h0);
      in_port = 4'b1011;
      tick(LAT + 1);
      rd(2'd3, 32'h4, "edge_bit2_set");
      tick(1);
      chk("irq_masked", {31'd0, bus.irq}, 32'd0);
      wr(2'd2, 32'hF);
      chk("irq_lags_mask", {31'd0, bus.irq}, 32'd0);
      tick(1);
      chk("irq_unmasked", {31'd0, bus.irq}, 32'd1);

      in_port = 4'hF;
      tick(LAT + 2);
      in_port = 4'b1011;
      tick(LAT + 2);
      rd(2'd3, 32'h4, "edge_sticky");
      wr(2'd3, 32'hF);
      rd(2'd3, 32'h0, "clear_all");
      tick(1);
      chk("irq_clear_all", {31'd0, bus.irq}, 32'd0);
      in_port = 4'hF;
      tick(LAT + 2);

      // Clear lands on the same edge that captures bit 0
      in_port = 4'hE;
      tick(LAT);
      wr(2'd3, 32'h1);
      rd(2'd3, 32'h1, "set_wins");
      tick(1);
      chk("irq_set_wins", {31'd0, bus.irq}, 32'd1);

      in_port = 4'h0;
      tick(LAT + 1);
      in_port = 4'hF;
      tick(LAT + 2);
      rd(2'd3, 32'hF, "edge_all_set");
      chk("irq_all_set", {31'd0, bus.irq}, 32'd1);
      #2;
      reset_n = 1'b0;
      rd(2'd3, 32'h0, "async_reset_edge");
      rd(2'd2, 32'h0, "async_reset_mask");
      chk("async_reset_irq", {31'd0, bus.irq}, 32'd0);
      tick(2);
      reset_n = 1'b1;
      tick(LAT + 4);
      rd(2'd3, 32'h0, "no_edge_after_release");
      rd(2'd0, 32'hF, "data_after_release");
      chk("irq_after_release", {31'd0, bus.irq}, 32'd0);

      // Bit 3 held low across reset release
      reset_n = 1'b0;
      in_port = 4'h7;
      tick(2);
      reset_n = 1'b1;
      tick(LAT);
      rd(2'd3, 32'h0, "held_low_not_yet");
      tick(1);
      rd(2'd3, 32'h8, "held_low_edge");
      tick(LAT + 2);
      rd(2'd3, 32'h8, "held_low_once");
      rd(2'd0, 32'h7, "held_low_data");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/keys_input_pio.md
KEYS_INPUT_PIO -- requirements
Module: keys_input_pio

Interface
REQ-001 Parameter WIDTH, default 4, number of input port bits.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000, stable-level hold cycles required by the debouncer (1 ms at 50 MHz).
REQ-003 Port clk  input  1  sole clock; all state on rising edge.
REQ-004 Port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port address  input  2  Avalon-MM word address.
REQ-006 Port chipselect  input  1  Avalon-MM slave select.
REQ-007 Port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 Port writedata  input  32  Avalon-MM write data.
REQ-009 Port in_port  input  WIDTH  asynchronous pushbutton inputs, active-low (idle 1).
REQ-010 Port readdata  output  32  Avalon-MM read data; zero wait states, zero read latency.
REQ-011 Port irq  output  1  level interrupt request, active-high.

Function
REQ-012 in_port SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-013 Register map SHALL be: addr 0 DATA (RO), addr 1 reserved, addr 2 IRQMASK (RW, WIDTH bits), addr 3 EDGECAP (R, write-1-to-clear).
REQ-014 readdata SHALL be combinational from address: DATA/IRQMASK/EDGECAP zero-extended to 32 bits; addr 1 reads 0.
REQ-015 Writes SHALL occur when chipselect=1 and write_n=0; writes to addr 0 and addr 1 SHALL be ignored.
REQ-016 Write to addr 2 SHALL load IRQMASK with writedata[WIDTH-1:0] on the same clock edge.
REQ-017 Write to addr 3 SHALL clear each EDGECAP bit whose writedata bit is 1; bits with writedata 0 are unchanged.
REQ-018 A falling edge (1->0) of the conditioned level (level = debounced value, or synchronized value when debouncing is compiled out) on bit i SHALL set EDGECAP[i] on the following edge; rising edges SHALL not set it.
REQ-019 Simultaneous edge detection and clear write on the same bit SHALL leave the bit set (set wins).
REQ-020 irq SHALL be registered: irq = OR over i of (EDGECAP[i] AND IRQMASK[i]), updating one cycle after EDGECAP/IRQMASK change.
REQ-021 EDGECAP bits SHALL be sticky until cleared; repeated edges on a set bit have no further effect.
REQ-022 DATA SHALL reflect the conditioned level; no read side effects on any register.

Reset
REQ-023 During reset_n=0: synchronizer, previous-level and debounced registers = all ones; debounce counters = 0; IRQMASK = 0; EDGECAP = 0; irq = 0.
REQ-024 Reset asserted mid-debounce or with pending EDGECAP SHALL discard all state immediately; no edge SHALL be reported on release if in_port is idle high.
REQ-025 After reset release, an in_port bit held low SHALL produce exactly one EDGECAP set, after the conditioning latency.

Configuration
REQ-026 Macro KEYS_INPUT_PIO_DEBOUNCE_EN defined: per-bit counter SHALL count consecutive cycles where the synchronized bit differs from the debounced bit; on reaching DEBOUNCE_CYCLES the debounced bit SHALL take the synchronized value and the counter SHALL reset to 0; any cycle where they agree SHALL reset the counter to 0.
REQ-027 Macro undefined: no counters SHALL be synthesized; conditioned level = synchronized level (edge visible 3 cycles after in_port change: 2 sync + 1 edge register).
REQ-028 Counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); DEBOUNCE_CYCLES < 1 is illegal.

Verification
REQ-029 Reset, then read addr 0/2/3 with in_port=4'hF -> 0x0000000F, 0x0, 0x0; irq=0.
REQ-030 Debounce off: write IRQMASK=4'b0010; drive in_port[1] low -> EDGECAP=4'b0010 within 3 cycles, irq=1 one cycle later; write addr 3 = 0x2 -> EDGECAP=0, irq=0 next cycle.
REQ-031 Debounce on, DEBOUNCE_CYCLES=8: glitch in_port[0] low for 5 cycles -> DATA unchanged 0xF, EDGECAP=0; hold low 12 cycles -> DATA=0xE, EDGECAP[0]=1.
REQ-032 Mask 0 with pending EDGECAP=4'b0100 -> irq=0; write IRQMASK=0xF -> irq=1 next cycle.
REQ-033 Clear write to addr 3 (0x1) in the same cycle a new falling edge sets bit 0 -> EDGECAP[0] stays 1.
REQ-034 Assert reset_n with EDGECAP=0xF, IRQMASK=0xF, in_port=0xF -> all registers 0, irq=0, no edges after release.
